countdown_timer_bcd: RTL and testbench

// - Parametrised BCD countdown timer: DIGITS decimal digits, loadable start value, start/pause control,

---
 rtl/counter_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 19 +
 rtl/countdown_timer_bcd.sv | 179 +++++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the BCD countdown timer: FSM state codes, 7-segment code table and BCD clamp.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package counter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_CODE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Anything above 9 is treated as 9 so the digit array never holds a non-BCD nibble.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-high pattern {g,f,e,d,c,b,a}.
// Non-BCD inputs produce a blank digit.
module seg7_decode
    import counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) begin
                seg = SEG_CODE[i];
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Loadable BCD countdown timer with start/pause control, scanned 7-segment drive and done LED.
// Build option COUNTDOWN_AUTORELOAD_EN: expiry reloads the last loaded value and pulses q2 instead of latching DONE.
//
// state   | meaning
// IDLE    | count loaded or held, waiting for start
// RUN     | prescaler running, count decrements on every tick
// PAUSED  | count and prescaler phase frozen
// DONE    | expired at zero, q2 high until start or load
module countdown_timer_bcd
    import counter_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int TICK_DIV    = 50,
    parameter int SCAN_DIV    = 8,
    parameter int SEG_ACT_LOW = 1
)(
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [6:0]            q,
    output logic [DIGITS-1:0]     dsel,
    output logic                  q2,
    output logic [4*DIGITS-1:0]   count_bcd
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [6:0]          Q_RST     = (SEG_ACT_LOW != 0) ? ~SEG_CODE[9] : SEG_CODE[9];

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [4*DIGITS-1:0] reload_q, reload_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                q2_q, q2_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]       scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]   dsel_q, dsel_d;
    logic [6:0]          q_q, q_d;

    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] count_dec;
    logic [DIGITS:0]     borrow;
    logic                count_zero;
    logic                tick;
    logic [3:0]          cur_digit;
    logic [6:0]          seg_raw;

    // Ripple borrow: a digit decrements only when every lower digit was 0.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] cur;
        assign cur                    = count_q[4*g +: 4];
        assign load_clamped[4*g +: 4] = bcd_clamp(load_val[4*g +: 4]);
        assign count_dec[4*g +: 4]    = !borrow[g]     ? cur :
                                        (cur == 4'd0)  ? 4'd9 : cur - 4'd1;
        assign borrow[g+1]            = borrow[g] & (cur == 4'd0);
    end

    assign count_zero = borrow[DIGITS];
    assign tick       = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        q2_d     = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (load) begin
            state_d  = ST_IDLE;
            count_d  = load_clamped;
            reload_d = load_clamped;
            presc_d  = '0;
        end else begin
            if (tick) begin
                if (count_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    count_d = reload_q;
                    q2_d    = 1'b1;
`else
                    state_d = ST_DONE;
                    presc_d = '0;
`endif
                end else begin
                    count_d = count_dec;
                end
            end

            if (pause && (state_q == ST_RUN)) begin
                state_d = ST_PAUSED;
            end else if (start && (state_q != ST_RUN)) begin
                state_d = ST_RUN;
                // Resume from PAUSED keeps prescaler phase; fresh runs start a full tick period.
                if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
                    presc_d = '0;
                end
                if (state_q == ST_DONE) begin
                    count_d = reload_q;
                end
            end
        end

`ifndef COUNTDOWN_AUTORELOAD_EN
        q2_d = (state_d == ST_DONE);
`endif
    end

    always_comb begin
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
            scan_idx_d = scan_idx_q;
        end
    end

    // Pattern and enable both derive from scan_idx_q so they always change on the same edge.
    always_comb begin
        cur_digit = 4'd0;
        dsel_d    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                cur_digit = count_q[4*i +: 4];
                dsel_d[i] = 1'b1;
            end
        end
    end

    seg7_decode u_seg7 (
        .bcd (cur_digit),
        .seg (seg_raw)
    );

    always_comb begin
        q_d = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
    end

    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= ALL_NINES;
            reload_q   <= ALL_NINES;
            presc_q    <= '0;
            q2_q       <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            dsel_q     <= DIGITS'(1);
            q_q        <= Q_RST;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            presc_q    <= presc_d;
            q2_q       <= q2_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            dsel_q     <= dsel_d;
            q_q        <= q_d;
        end
    end

    assign q         = q_q;
    assign dsel      = dsel_q;
    assign q2        = q2_q;
    assign count_bcd = count_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd (DIGITS=2, TICK_DIV=4, SCAN_DIV=2, active-low segments).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_countdown_timer_bcd;

    localparam logic [6:0] Q9_AL = 7'h10;
    localparam logic [6:0] Q7_AL = 7'h78;
    localparam logic [6:0] Q3_AL = 7'h30;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [6:0] q;
    logic [1:0] dsel;
    logic       q2;
    logic [7:0] count_bcd;

    always #5 clk_sys = ~clk_sys;

    countdown_timer_bcd #(
        .DIGITS      (2),
        .TICK_DIV    (4),
        .SCAN_DIV    (2),
        .SEG_ACT_LOW (1)
    ) dut (
        .clkIn     (clk_sys),
        .rst       (rst_n),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .q         (q),
        .dsel      (dsel),
        .q2        (q2),
        .count_bcd (count_bcd)
    );

    typedef struct {
        int              cyc;
        logic [7:0]      cnt;
        logic            q2v;
        logic            chk_disp;
        logic [1:0]      dsel;
        logic [6:0]      q;
        logic [8*12-1:0] nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %0s: check for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (count_bcd !== e.cnt || q2 !== e.q2v ||
                         (e.chk_disp && (dsel !== e.dsel || q !== e.q))) begin
                bad++;
                $display("FAIL %0s: cyc=%0d got count=%h q2=%b dsel=%b q=%h, want count=%h q2=%b dsel=%b q=%h",
                         e.nm, cyc, count_bcd, q2, dsel, q, e.cnt, e.q2v, e.dsel, e.q);
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic exp_cnt(input int c, input logic [7:0] cnt, input logic q2v, input logic [8*12-1:0] nm);
        exp_t e;
        e.cyc = c; e.cnt = cnt; e.q2v = q2v; e.chk_disp = 1'b0;
        e.dsel = 2'b00; e.q = 7'h00; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic exp_disp(input int c, input logic [7:0] cnt, input logic q2v,
                            input logic [1:0] ds, input logic [6:0] qv, input logic [8*12-1:0] nm);
        exp_t e;
        e.cyc = c; e.cnt = cnt; e.q2v = q2v; e.chk_disp = 1'b1;
        e.dsel = ds; e.q = qv; e.nm = nm;
        sb.push_back(e);
    endtask

    // Drives a one-cycle pulse; e0 is the clock edge that samples it.
    task automatic pulse(input logic l, input logic [7:0] v, input logic s, input logic p, output int e0);
        load = l; load_val = v; start = s; pause = p;
        e0 = cyc + 1;
        step();
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached", sb.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e0, s0, r0, c;
        logic [1:0] prev_dsel;
        bit found;

        rst_n = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;

        // Reset values
        step();
        exp_disp(cyc, 8'h99, 1'b0, 2'b01, Q9_AL, "reset");
        step();
        rst_n = 1'b1;
        exp_cnt(cyc + 6, 8'h99, 1'b0, "idle_hold");
        drain();

        // Basic countdown to terminal
        pulse(1'b1, 8'h05, 1'b0, 1'b0, e0);
        exp_cnt(e0, 8'h05, 1'b0, "load05");
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 3, 8'h05, 1'b0, "pre_tick");
        exp_cnt(s0 + 4, 8'h04, 1'b0, "dec04");
        exp_cnt(s0 + 8, 8'h03, 1'b0, "dec03");
        exp_cnt(s0 + 16, 8'h01, 1'b0, "dec01");
        exp_cnt(s0 + 20, 8'h00, 1'b0, "dec00");
        exp_cnt(s0 + 23, 8'h00, 1'b0, "zero_hold");
`ifdef COUNTDOWN_AUTORELOAD_EN
        exp_cnt(s0 + 24, 8'h05, 1'b1, "reload05");
        exp_cnt(s0 + 25, 8'h05, 1'b0, "q2_pulse");
        exp_cnt(s0 + 28, 8'h04, 1'b0, "rerun04");
        drain();
`else
        exp_cnt(s0 + 24, 8'h00, 1'b1, "done");
        exp_cnt(s0 + 30, 8'h00, 1'b1, "done_hold");
        drain();
        pulse(1'b0, 8'h00, 1'b1, 1'b0, r0);
        exp_cnt(r0, 8'h05, 1'b0, "done_reload");
        exp_cnt(r0 + 4, 8'h04, 1'b0, "done_rerun");
        drain();
`endif

        // Borrow across digits, then clamp of non-BCD load
        pulse(1'b1, 8'h10, 1'b0, 1'b0, e0);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h09, 1'b0, "borrow09");
        exp_cnt(s0 + 8, 8'h08, 1'b0, "dec08");
        drain();
        pulse(1'b1, 8'hA3, 1'b0, 1'b0, e0);
        exp_cnt(e0, 8'h93, 1'b0, "clamp93");
        drain();

        // Pause two cycles before a tick, hold, resume keeps phase
        pulse(1'b1, 8'h50, 1'b0, 1'b0, e0);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h49, 1'b0, "pz_dec49");
        step_to(s0 + 5);
        pulse(1'b0, 8'h00, 1'b0, 1'b1, e0);
        exp_cnt(s0 + 8, 8'h49, 1'b0, "pz_frozen1");
        exp_cnt(s0 + 26, 8'h49, 1'b0, "pz_frozen2");
        step_to(s0 + 26);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, r0);
        exp_cnt(r0 + 1, 8'h49, 1'b0, "pz_resume1");
        exp_cnt(r0 + 2, 8'h48, 1'b0, "pz_resume2");
        exp_cnt(r0 + 6, 8'h47, 1'b0, "pz_next");
        drain();

        // load + start + pause together while running
        pulse(1'b1, 8'h42, 1'b1, 1'b1, e0);
        exp_cnt(e0, 8'h42, 1'b0, "prio_load");
        exp_cnt(e0 + 12, 8'h42, 1'b0, "prio_idle");
        drain();
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h41, 1'b0, "prio_start");
        drain();

        // Start from zero in IDLE
        pulse(1'b1, 8'h00, 1'b0, 1'b0, e0);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 3, 8'h00, 1'b0, "z_run");
        exp_cnt(s0 + 4, 8'h00, 1'b1, "z_expire");
`ifdef COUNTDOWN_AUTORELOAD_EN
        exp_cnt(s0 + 5, 8'h00, 1'b0, "z_pulse");
`else
        exp_cnt(s0 + 5, 8'h00, 1'b1, "z_done");
`endif
        drain();

        // Async reset mid-run
        pulse(1'b1, 8'h25, 1'b0, 1'b0, e0);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h24, 1'b0, "ar_dec24");
        step_to(s0 + 6);
        rst_n = 1'b0;
        exp_disp(cyc, 8'h99, 1'b0, 2'b01, Q9_AL, "async_rst");
        step();
        step();
        rst_n = 1'b1;
        c = cyc;
        exp_cnt(c + 10, 8'h99, 1'b0, "ar_idle");
        drain();
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h98, 1'b0, "ar_start");
        drain();

        // Display scan with count 37
        pulse(1'b1, 8'h37, 1'b0, 1'b0, e0);
        step(); step(); step();
        prev_dsel = dsel;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (dsel == 2'b01 && prev_dsel == 2'b10) found = 1'b1;
            prev_dsel = dsel;
        end
        if (!found) begin
            $display("FAIL scan_sync: dsel never moved 10 -> 01, got dsel=%b", dsel);
            $fatal(1, "scan stalled");
        end
        c = cyc;
        for (int k = 1; k <= 8; k++) begin
            if (((k + 0) % 4) < 2) exp_disp(c + k, 8'h37, 1'b0, 2'b01, Q7_AL, "scan_d0");
            else                   exp_disp(c + k, 8'h37, 1'b0, 2'b10, Q3_AL, "scan_d1");
        end
        drain();

        // Expiry at 02 -> 01 -> 00
        pulse(1'b1, 8'h02, 1'b0, 1'b0, e0);
        pulse(1'b0, 8'h00, 1'b1, 1'b0, s0);
        exp_cnt(s0 + 4, 8'h01, 1'b0, "ex_dec01");
        exp_cnt(s0 + 8, 8'h00, 1'b0, "ex_dec00");
`ifdef COUNTDOWN_AUTORELOAD_EN
        exp_cnt(s0 + 12, 8'h02, 1'b1, "ex_reload");
        exp_cnt(s0 + 13, 8'h02, 1'b0, "ex_pulse");
        exp_cnt(s0 + 16, 8'h01, 1'b0, "ex_rerun");
`else
        exp_cnt(s0 + 12, 8'h00, 1'b1, "ex_done");
        exp_cnt(s0 + 13, 8'h00, 1'b1, "ex_latch");
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
